// File: rtl/tic_tac_toe_auto_player_pkg.sv
// ttt_pkg: shared states, board geometry and move scores for the auto player
package ttt_pkg;
  typedef enum logic [2:0] {IDLE, SCAN, THINK, PRESS, WAIT_ACK} state_t;
  localparam int NUM_CELLS = 9;
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
  localparam logic [2:0] SCORE_WIN = 3'd4;
  localparam logic [2:0] SCORE_BLOCK = 3'd3;
  localparam logic [2:0] SCORE_CENTER = 3'd2;
  localparam logic [2:0] SCORE_CORNER = 3'd1;
  localparam logic [2:0] SCORE_EDGE = 3'd0;
  function automatic logic [1:0] line_count(logic [NUM_CELLS-1:0] cells, int l);
    return 2'(cells[LINES[l][0]]) + 2'(cells[LINES[l][1]]) + 2'(cells[LINES[l][2]]);
  endfunction
endpackage

// File: rtl/tic_tac_toe_auto_player_if.sv
// tic_tac_toe_auto_player_if: board/turn inputs and move outputs of the auto player
interface tic_tac_toe_auto_player_if;
  import ttt_pkg::*;
  logic enable, my_turn, game_over;
  logic [NUM_CELLS-1:0] p1_cells, p2_cells, button;
  logic busy, ack_err;
  logic [3:0] move_idx;
  modport master(output enable, my_turn, game_over, p1_cells, p2_cells, input button, busy, move_idx, ack_err);
  modport slave(input enable, my_turn, game_over, p1_cells, p2_cells, output button, busy, move_idx, ack_err);
endinterface

// File: rtl/tic_tac_toe_auto_player_cell_score.sv
// ttt_cell_score: scores one square for player 2 (win > block > centre > corner > edge)
module ttt_cell_score
  import ttt_pkg::*;
(
  input  logic [NUM_CELLS-1:0] p1_cells,
  input  logic [NUM_CELLS-1:0] p2_cells,
  input  logic [3:0]           idx,
  output logic [2:0]           score,
  output logic                 empty
);
  logic win, blk, corner;
  // a line through an empty idx with two marks of one player means its other two squares hold them
  always_comb begin
    win = 1'b0;
    blk = 1'b0;
    for (int l = 0; l < 8; l++) begin
      win = win | ((idx == LINES[l][0] || idx == LINES[l][1] || idx == LINES[l][2]) && line_count(p2_cells, l) == 2'd2);
      blk = blk | ((idx == LINES[l][0] || idx == LINES[l][1] || idx == LINES[l][2]) && line_count(p1_cells, l) == 2'd2);
    end
  end
  assign empty = ~(p1_cells[idx] | p2_cells[idx]);
  assign corner = idx == 4'd0 || idx == 4'd2 || idx == 4'd6 || idx == 4'd8;
  assign score = !empty ? SCORE_EDGE : win ? SCORE_WIN : blk ? SCORE_BLOCK :
                 idx == 4'd4 ? SCORE_CENTER : corner ? SCORE_CORNER : SCORE_EDGE;
endmodule

// File: rtl/tic_tac_toe_auto_player.sv
// tic_tac_toe_auto_player: scans the board, picks player 2's move, presses it and checks the ack
module tic_tac_toe_auto_player
  import ttt_pkg::*;
#(
  parameter int THINK_CYCLES = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input logic clk,
  input logic reset,
  tic_tac_toe_auto_player_if.slave bus
);
  state_t state, nxt;
  logic [3:0] idx, best_idx, move_idx;
  logic [2:0] score, best_score;
  logic [15:0] think_cnt;
  logic [7:0] ack_cnt;
  logic [NUM_CELLS-1:0] button;
  logic empty, take, best_valid, go, last, acked, timeout, ack_err;
  ttt_cell_score u_score (
    .p1_cells(bus.p1_cells),
    .p2_cells(bus.p2_cells),
    .idx(idx),
    .score(score),
    .empty(empty)
  );
  assign go = bus.enable & bus.my_turn & ~bus.game_over;
  assign take = empty & (~best_valid | score > best_score);
  assign last = idx == 4'(NUM_CELLS - 1);
  assign acked = bus.p2_cells[move_idx];
  assign timeout = state == WAIT_ACK && !acked && ack_cnt == 8'(ACK_TIMEOUT - 1) && bus.enable;
  assign bus.button = button;
  assign bus.busy = state != IDLE;
  assign bus.move_idx = move_idx;
  assign bus.ack_err = ack_err;
  // next state; enable low always parks the block, WAIT_ACK deliberately ignores my_turn
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     nxt = go ? SCAN : IDLE;
      SCAN:     nxt = !go ? IDLE : !last ? SCAN : (take | best_valid) ? THINK : IDLE;
      THINK:    nxt = !go ? IDLE : think_cnt == 16'(THINK_CYCLES - 1) ? PRESS : THINK;
      PRESS:    nxt = WAIT_ACK;
      WAIT_ACK: nxt = (acked | timeout) ? IDLE : WAIT_ACK;
      default:  nxt = IDLE;
    endcase
    if (!bus.enable) nxt = IDLE;
  end
  // state, scan/best registers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      best_valid <= 1'b0;
      best_score <= '0;
      best_idx <= '0;
      move_idx <= '0;
      think_cnt <= '0;
      ack_cnt <= '0;
      button <= '0;
      ack_err <= 1'b0;
    end else begin
      state <= nxt;
      idx <= state == SCAN ? idx + 4'd1 : 4'd0;
      best_valid <= state == SCAN && (best_valid | take);
      best_score <= (state == SCAN && take) ? score : best_score;
      best_idx <= (state == SCAN && take) ? idx : best_idx;
      move_idx <= (state == SCAN && nxt == THINK) ? (take ? idx : best_idx) : move_idx;
      think_cnt <= state == THINK ? think_cnt + 16'd1 : 16'd0;
      ack_cnt <= state == WAIT_ACK ? ack_cnt + 8'd1 : 8'd0;
      button <= nxt == PRESS ? NUM_CELLS'(1) << move_idx : '0;
      ack_err <= ack_err | timeout;
    end
  end
endmodule

// File: tb/tb_tic_tac_toe_auto_player.sv
// tb_tic_tac_toe_auto_player: directed checks plus a scoreboard of button pulses
module tb_tic_tac_toe_auto_player;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  tic_tac_toe_auto_player_if bus();
  tic_tac_toe_auto_player #(.THINK_CYCLES(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // every non-zero button seen mid-cycle is a pulse to be matched against the scoreboard
  always @(negedge clk) if (bus.button !== 9'h0) got_q.push_back(bus.button);
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic move(string tag, logic [8:0] p1, logic [8:0] p2, logic [8:0] exp_b, logic [3:0] exp_i);
    bus.p1_cells = p1;
    bus.p2_cells = p2;
    bus.my_turn = 1'b1;
    exp_q.push_back(exp_b);
    step(13);
    chk({tag, "_early"}, bus.button, 9'h0);
    step(1);
    chk({tag, "_button"}, bus.button, exp_b);
    chk({tag, "_idx"}, bus.move_idx, exp_i);
    bus.p2_cells = p2 | exp_b;
    bus.my_turn = 1'b0;
    step(1);
    chk({tag, "_pulse_end"}, bus.button, 9'h0);
    chk({tag, "_wait_busy"}, bus.busy, 1'b1);
    step(1);
    chk({tag, "_idle"}, bus.busy, 1'b0);
  endtask
  initial begin
    bus.enable = 1'b0;
    bus.my_turn = 1'b0;
    bus.game_over = 1'b0;
    bus.p1_cells = '0;
    bus.p2_cells = '0;
    step(2);
    reset = 1'b0;
    chk("rst_button", bus.button, 9'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_idx", bus.move_idx, 4'd0);
    chk("rst_err", bus.ack_err, 1'b0);
    bus.enable = 1'b1;
    move("empty", 9'h000, 9'h000, 9'h010, 4'd4);
    move("win_over_block", 9'h018, 9'h003, 9'h004, 4'd2);
    move("block", 9'h003, 9'h010, 9'h004, 4'd2);
    move("corner", 9'h010, 9'h000, 9'h001, 4'd0);
    move("win_high_idx", 9'h003, 9'h0C0, 9'h100, 4'd8);
    // full board: nine scan cycles, then back to IDLE with no press
    bus.p1_cells = 9'h1F0;
    bus.p2_cells = 9'h00F;
    bus.my_turn = 1'b1;
    step(9);
    chk("full_busy_scan", bus.busy, 1'b1);
    step(1);
    chk("full_idle", bus.busy, 1'b0);
    bus.my_turn = 1'b0;
    step(2);
    chk("full_idx_held", bus.move_idx, 4'd8);
    // game_over rising in THINK aborts the move
    bus.p1_cells = '0;
    bus.p2_cells = '0;
    bus.my_turn = 1'b1;
    step(11);
    chk("abort_think_busy", bus.busy, 1'b1);
    bus.game_over = 1'b1;
    step(1);
    chk("abort_idle", bus.busy, 1'b0);
    step(6);
    chk("abort_no_pulse", bus.button, 9'h0);
    bus.game_over = 1'b0;
    bus.my_turn = 1'b0;
    step(1);
    // press never acknowledged: ack_err rises eight cycles into WAIT_ACK and stays
    bus.my_turn = 1'b1;
    exp_q.push_back(9'h010);
    step(14);
    chk("to_button", bus.button, 9'h010);
    step(8);
    chk("to_err_early", bus.ack_err, 1'b0);
    step(1);
    chk("to_err_set", bus.ack_err, 1'b1);
    chk("to_idle", bus.busy, 1'b0);
    bus.my_turn = 1'b0;
    step(5);
    chk("to_err_sticky", bus.ack_err, 1'b1);
    // reset in the PRESS cycle clears everything from the next edge
    bus.my_turn = 1'b1;
    exp_q.push_back(9'h010);
    step(14);
    chk("rp_button", bus.button, 9'h010);
    reset = 1'b1;
    step(1);
    chk("rp_button_clr", bus.button, 9'h0);
    chk("rp_busy", bus.busy, 1'b0);
    chk("rp_idx", bus.move_idx, 4'd0);
    chk("rp_err", bus.ack_err, 1'b0);
    reset = 1'b0;
    bus.my_turn = 1'b0;
    step(3);
    chk("pulse_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) chk("sb_pulse", got_q.pop_front(), exp_q.pop_front());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
